// File: rtl/cacheline_burst_adapter.sv
// Whole-line <-> fixed-length burst adapter between the cache and physical memory.
// Fills assemble beats into line_o; writebacks snapshot line_i and stream it out beat by beat.
module cacheline_burst_adapter #(
  parameter int s_offset = 5,
  parameter int s_beat   = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          read_i,
  input  logic                          write_i,
  input  logic [31:0]                   address_i,
  input  logic [(8*(2**s_offset))-1:0]  line_i,
  output logic [(8*(2**s_offset))-1:0]  line_o,
  output logic                          resp_o,
  output logic [31:0]                   address_o,
  output logic                          read_o,
  output logic                          write_o,
  output logic [s_beat-1:0]             burst_o,
  input  logic [s_beat-1:0]             burst_i,
  input  logic                          resp_i
);

  // state | meaning
  // IDLE  | waiting for a fill or writeback request
  // RD    | collecting fill beats from memory
  // WR    | streaming writeback beats to memory
  // DONE  | one-cycle completion pulse on resp_o
  localparam int line_w = 8 * (2 ** s_offset);
  localparam int nb     = line_w / s_beat;
  localparam int cw     = $clog2(nb);
  localparam logic [31:0] addr_mask = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                        state, state_nxt;
  logic [cw-1:0]                 cnt;
  logic [31:0]                   addr_q;
  logic [nb-1:0][s_beat-1:0]     line_q;
  logic [nb-1:0][s_beat-1:0]     wbuf;
  logic                          last_beat;

  assign last_beat = resp_i && (cnt == cw'(nb - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    read_o    = 1'b0;
    write_o   = 1'b0;
    resp_o    = 1'b0;
    case (state)
      IDLE: begin
        if (read_i)       state_nxt = RD;
        else if (write_i) state_nxt = WR;
      end
      RD: begin
        read_o = 1'b1;
        if (last_beat) state_nxt = DONE;
      end
      WR: begin
        write_o = 1'b1;
        if (last_beat) state_nxt = DONE;
      end
      DONE: begin
        resp_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat counter wraps back to 0 on the last beat, so no explicit clear is needed in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      addr_q <= '0;
      line_q <= '0;
      wbuf   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read_i) begin
            addr_q <= address_i & addr_mask;
            cnt    <= '0;
          end else if (write_i) begin
            addr_q <= address_i & addr_mask;
            wbuf   <= line_i;
            cnt    <= '0;
          end
        end
        RD: begin
          if (resp_i) begin
            line_q[cnt] <= burst_i;
            cnt         <= cnt + cw'(1);
          end
        end
        WR: begin
          if (resp_i) cnt <= cnt + cw'(1);
        end
        default: ;
      endcase
    end
  end

  assign line_o    = line_q;
  assign address_o = addr_q;
  assign burst_o   = (state == WR) ? wbuf[cnt] : '0;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Scoreboard bench for cacheline_burst_adapter: default 4-beat instance plus a 2-beat (s_beat=128) instance.
module tb_cacheline_burst_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         read_i, write_i, resp_i;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [63:0]  burst_i;
  logic [255:0] line_o;
  logic         resp_o, read_o, write_o;
  logic [31:0]  address_o;
  logic [63:0]  burst_o;

  logic         read2_i, write2_i, resp2_i;
  logic [127:0] burst2_i, burst2_o;
  logic [255:0] line2_o;
  logic         resp2_o, read2_o, write2_o;
  logic [31:0]  address2_o;

  always #5 clk = ~clk;

  cacheline_burst_adapter u_dut (
    .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i), .address_i(address_i),
    .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
  );

  cacheline_burst_adapter #(.s_offset(5), .s_beat(128)) u_dut2 (
    .clk(clk), .rst(rst), .read_i(read2_i), .write_i(write2_i), .address_i(address_i),
    .line_i(line_i), .line_o(line2_o), .resp_o(resp2_o), .address_o(address2_o),
    .read_o(read2_o), .write_o(write2_o), .burst_o(burst2_o), .burst_i(burst2_i), .resp_i(resp2_i)
  );

  typedef struct {
    logic [255:0] line;
    logic [31:0]  addr;
    int           req;
    int           lat;
    int           rdc;
    int           wrc;
  } exp_t;

  exp_t         q[$];
  exp_t         q2[$];
  logic [63:0]  bq[$];
  logic [127:0] bq2[$];
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;
  int           rd_seen = 0;
  int           wr_seen = 0;
  logic [255:0] model_line = '0;
  logic [255:0] model2_line = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for the default instance
  always @(negedge clk) begin
    if (!rst) begin
      if (read_o)  rd_seen++;
      if (write_o) wr_seen++;
      if (write_o && resp_i) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_unexpected: got %h expected none", burst_o);
        end else chk("burst_o", burst_o, bq.pop_front());
      end
      if (!write_o) chk("burst_o_idle", burst_o, '0);
      if (resp_o) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected: got resp_o=1 expected 0 at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("line_o", line_o, e.line);
          chk("address_o", address_o, e.addr);
          chk("latency", cyc - e.req, e.lat);
          chk("read_o_cycles", rd_seen, e.rdc);
          chk("write_o_cycles", wr_seen, e.wrc);
        end
        rd_seen = 0;
        wr_seen = 0;
      end
    end
  end

  // Monitor for the 2-beat instance
  always @(negedge clk) begin
    if (!rst) begin
      if (write2_o && resp2_i) begin
        if (bq2.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat2_unexpected: got %h expected none", burst2_o);
        end else chk("burst2_o", burst2_o, bq2.pop_front());
      end
      if (resp2_o) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp2_unexpected: got resp_o=1 expected 0 at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = q2.pop_front();
          chk("line2_o", line2_o, e.line);
          chk("address2_o", address2_o, e.addr);
          chk("latency2", cyc - e.req, e.lat);
        end
      end
    end
  end

  // All tasks start and end at #1 after a posedge, in a cycle where the DUT is in IDLE.
  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
    q.delete(); bq.delete(); q2.delete(); bq2.delete();
    rd_seen = 0; wr_seen = 0;
    model_line = '0; model2_line = '0;
    @(negedge clk);
    chk("rst_line_o", line_o, '0);
    chk("rst_resp_o", resp_o, 0);
    chk("rst_address_o", address_o, 0);
    chk("rst_read_o", read_o, 0);
    chk("rst_write_o", write_o, 0);
    chk("rst_burst_o", burst_o, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0][63:0] beats,
                         input int n, input logic [15:0] pat, input bit also_write,
                         input bit done_strobe);
    exp_t e;
    int   k;
    read_i = 1'b1; write_i = also_write; address_i = a;
    line_i = {8{$urandom}};
    model_line = beats;
    e.line = beats; e.addr = a & 32'hFFFF_FFE0; e.req = cyc; e.lat = n + 1; e.rdc = n; e.wrc = 0;
    q.push_back(e);
    k = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      read_i = 1'b0; write_i = 1'b0;
      resp_i = pat[i];
      if (pat[i]) begin burst_i = beats[k]; k++; end
      else burst_i = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    resp_i = done_strobe; burst_i = {$urandom, $urandom};
    @(posedge clk); #1;
    resp_i = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [255:0] l,
                          input int n, input logic [15:0] pat);
    exp_t e;
    write_i = 1'b1; address_i = a; line_i = l;
    e.line = model_line; e.addr = a & 32'hFFFF_FFE0; e.req = cyc; e.lat = n + 1; e.rdc = 0; e.wrc = n;
    q.push_back(e);
    for (int i = 0; i < 4; i++) bq.push_back(l[64*i +: 64]);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      write_i = 1'b0; line_i = ~l;
      resp_i = pat[i]; burst_i = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    resp_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][63:0] b1, b2, b3;
    logic [255:0]     wl;
    rst = 1'b1; read_i = 0; write_i = 0; resp_i = 0; address_i = '0; line_i = '0; burst_i = '0;
    read2_i = 0; write2_i = 0; resp2_i = 0; burst2_i = '0;
    #1;
    apply_reset(3);

    // Read, no gaps
    b1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    do_read(32'h0000_1234, b1, 4, 16'b1111, 1'b0, 1'b0);

    // Write with gaps: pattern 1,0,0,1,1,0,1 (slot 0 in bit 0)
    wl = {{8{8'hD3}}, {8{8'hD2}}, {8{8'hD1}}, {8{8'hD0}}};
    do_write(32'h0000_ABCD, wl, 7, 16'b1011001);

    // Simultaneous requests: read wins
    b2 = {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001};
    do_read(32'h0000_2040, b2, 5, 16'b11011, 1'b1, 1'b0);

    // Reset after 2 of 4 read beats
    read_i = 1'b1; address_i = 32'h0000_3000;
    @(posedge clk); #1; read_i = 1'b0; resp_i = 1'b1; burst_i = 64'hBAD0_BAD0_BAD0_0000;
    @(posedge clk); #1; burst_i = 64'hBAD0_BAD0_BAD0_0001;
    @(posedge clk); #1; resp_i = 1'b0;
    apply_reset(1);
    b3 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h0F0F_0F0F_0F0F_0F0F, 64'hA5A5_A5A5_A5A5_A5A5};
    do_read(32'h0000_301F, b3, 4, 16'b1111, 1'b0, 1'b0);

    // Stray strobes in IDLE
    resp_i = 1'b1; burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_strobe_line", line_o, model_line);
      chk("idle_strobe_req", {read_o, write_o}, 0);
      @(posedge clk); #1;
    end
    resp_i = 1'b0;

    // Read with stray strobe in DONE, then write back-to-back
    do_read(32'h0000_4444, b2, 4, 16'b1111, 1'b0, 1'b1);
    @(negedge clk);
    chk("done_strobe_line", line_o, model_line);
    @(posedge clk); #1;
    do_read(32'h0000_5000, b1, 4, 16'b1111, 1'b0, 1'b0);
    do_write(32'h0000_6008, ~wl, 4, 16'b1111);

    // 2-beat instance: read then write
    begin
      exp_t e;
      read2_i = 1'b1; address_i = 32'h0000_5678;
      model2_line = {b3[3], b3[2], b1[1], b1[0]};
      e.line = model2_line; e.addr = 32'h0000_5660; e.req = cyc; e.lat = 3; e.rdc = 0; e.wrc = 0;
      q2.push_back(e);
      @(posedge clk); #1; read2_i = 1'b0; resp2_i = 1'b1; burst2_i = model2_line[127:0];
      @(posedge clk); #1; burst2_i = model2_line[255:128];
      @(posedge clk); #1; resp2_i = 1'b0;
      @(posedge clk); #1;
      write2_i = 1'b1; address_i = 32'h0000_7FFF; line_i = wl;
      e.line = model2_line; e.addr = 32'h0000_7FE0; e.req = cyc; e.lat = 3;
      q2.push_back(e);
      bq2.push_back(wl[127:0]); bq2.push_back(wl[255:128]);
      @(posedge clk); #1; write2_i = 1'b0; line_i = '0; resp2_i = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1; resp2_i = 1'b0;
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("pending_resp", q.size(), 0);
    chk("pending_beats", bq.size(), 0);
    chk("pending_resp2", q2.size(), 0);
    chk("pending_beats2", bq2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cacheline_burst_adapter.md
# cacheline_burst_adapter

- Converts whole-line cache transfers into fixed-length bursts on the physical-memory port, and bursts back into whole lines.
- Sits between the cache controller and data array on one side and physical memory on the other.
- A fill assembles a line into `line_o`, which the controller writes into the data array with all byte enables set.
- A writeback takes a dirty line from the data array's read port on `line_i` and streams it out beat by beat.

## Interface
- `s_offset`, default 5: log2 of line size in bytes; the line is 8·2^s_offset bits (256).
- `s_beat`, default 64: burst beat width in bits. Beats per line are NB = line bits / s_beat (4). NB must be a power of two and ≥ 2.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `read_i`, in, 1: line fill request from the cache controller.
- `write_i`, in, 1: line writeback request from the cache controller.
- `address_i`, in, 32: byte address of the line.
- `line_i`, in, line bits: writeback data, taken from the data array output.
- `line_o`, out, line bits: assembled fill data for the data array `datain`.
- `resp_o`, out, 1: one-cycle pulse marking completion of a line transfer.
- `address_o`, out, 32: line-aligned memory address.
- `read_o`, out, 1: memory burst read request.
- `write_o`, out, 1: memory burst write request.
- `burst_o`, out, s_beat: outgoing write beat.
- `burst_i`, in, s_beat: incoming read beat.
- `resp_i`, in, 1: memory beat strobe; one beat moves per cycle in which it is high.

## Operation
- States: IDLE, RD, WR, DONE. Beat counter `cnt` is log2(NB) bits.
- **Reset:**
  - State goes to IDLE and `cnt` to 0.
  - `line_o`, `resp_o`, `address_o`, `read_o`, `write_o` and `burst_o` are all 0.
  - Reset mid-burst abandons the transfer; no `resp_o` is produced.
- **IDLE:**
  - `read_i` = 1 → latch `address_i` with the low s_offset bits forced to 0, clear `cnt`, go to RD.
  - `write_i` = 1 → latch the address the same way, latch `line_i` into an internal write buffer, clear `cnt`, go to WR.
  - `read_i` and `write_i` both high → the read wins; `write_i` is ignored.
  - `resp_i` in IDLE is ignored.
- **RD:**
  - `read_o` = 1 and `address_o` = the latched address.
  - On each cycle with `resp_i` = 1: `line_o[cnt·s_beat +: s_beat]` ← `burst_i`, then `cnt` increments.
  - When the beat at `cnt` = NB−1 is accepted, go to DONE.
- **WR:**
  - `write_o` = 1, `address_o` = the latched address, `burst_o` = `wbuf[cnt·s_beat +: s_beat]` (combinational on `cnt`).
  - On each `resp_i` = 1, `cnt` increments; the beat at `cnt` = NB−1 goes to DONE.
  - `line_i` changes after acceptance have no effect.
- **Memory handshake:**
  - Gaps are allowed: `resp_i` may be low for any number of cycles between beats.
  - `read_o`/`write_o` stay high continuously until the last beat is accepted.
- **DONE:**
  - `resp_o` = 1 for exactly this one cycle; `read_o` = `write_o` = 0. Go to IDLE unconditionally.
  - `resp_i` in DONE is ignored.
- **Outputs between transfers:**
  - `line_o` holds the last assembled line until the next fill's first beat. A writeback never modifies `line_o`.
  - `address_o` holds its last value; `burst_o` = 0 whenever the state is not WR.
- **Requester rule:** deassert `read_i`/`write_i` in the cycle after `resp_o`. A request still high in IDLE starts a new transfer.

## Timing
- Request sampled in IDLE at edge N → `read_o`/`write_o` high from cycle N+1.
- Memory may strobe `resp_i` in that first cycle.
- With `resp_i` high in cycles N+1..N+NB, `resp_o` is high in cycle N+NB+1. Minimum latency is NB+1 cycles from request to response (5 by default).
- `line_o` is complete in the same cycle as `resp_o`; the controller may write the data array in that cycle.
- Each gap cycle in `resp_i` adds exactly one cycle of latency.
- Back-to-back transfers: earliest new request acceptance is the cycle after DONE.

## Test plan
- **Read, no gaps:**
  - Stimulus: reset, then `read_i` = 1 with `address_i` = 0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles.
  - Response: `address_o` = 0x0000_1220 and `read_o` high for 4 cycles.
  - `resp_o` pulses once at request+5; `line_o` = {0x44..44, 0x33..33, 0x22..22, 0x11..11} (beat 0 in the low bits).
- **Write with gaps:**
  - Stimulus: `write_i` with `line_i` = {D3,D2,D1,D0}; `line_i` changes after acceptance; `resp_i` pattern 1,0,0,1,1,0,1.
  - Response: `burst_o` presents D0, D1, D2, D3 in order; `write_o` is high for 7 cycles; `resp_o` pulses at request+8; `line_o` is unchanged.
- **Simultaneous requests:**
  - Stimulus: `read_i` and `write_i` both high in IDLE.
  - Response: a read burst only; `write_o` never asserts.
- **Reset mid-burst:**
  - Stimulus: `rst` asserted after 2 of 4 read beats, then a new read.
  - Response: all outputs 0 the cycle after reset and no `resp_o`; the new read completes normally with `cnt` restarted at 0.
- **Stray strobes and back-to-back:**
  - Stimulus: `resp_i` pulses in IDLE and in DONE; then a read followed immediately by a write.
  - Response: stray strobes do not change state or `line_o`; the second transfer starts the cycle after DONE.
- **Non-default parameters:**
  - Stimulus: `s_beat` = 128.
  - Response: 2-beat bursts; `resp_o` at request+3.
